conv_encoder_framed: RTL and testbench

Rate-1/2 convolutional encoder with frame control and zero-tail termination. It sits on the transmit side of the Viterbi link and feeds 2-bit codewords into the channel and decoder path. It accepts info bits with a valid/ready handshake and counts FRAME_LEN bits per frame. It then appends K-1 zero tail bits so that every frame ends with the trellis in state 0, which is the state the decoder expects.

---
 rtl/conv_encoder_framed.sv | 140 ++++++++++++++
 tb/tb_conv_encoder_framed.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder_framed.sv
// Rate-1/2 convolutional encoder with frame markers and optional zero-tail termination.
// Build option CONV_ENC_TAIL_EN: append K-1 flush codewords per frame; otherwise frames stream back to back.
//
// state | meaning
// IDLE  | waiting for the first bit of a frame (cnt = 0)
// DATA  | accepting the remaining info bits of the frame
// TAIL  | emitting K-1 zero-input flush codewords (CONV_ENC_TAIL_EN only)
module conv_encoder_framed #(
    parameter int unsigned    K         = 3,
    parameter logic [K-1:0]   G0        = 3'b111,
    parameter logic [K-1:0]   G1        = 3'b101,
    parameter int unsigned    FRAME_LEN = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic       d_in,
    output logic       ready_o,
    output logic       valid_o,
    output logic [1:0] d_out,
    output logic       frame_start_o,
    output logic       frame_end_o
);
    localparam int unsigned   CW       = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);

`ifdef CONV_ENC_TAIL_EN
    localparam int unsigned   TW        = $clog2(K);
    localparam logic [TW-1:0] TAIL_LAST = TW'(K - 2);

    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, TAIL = 2'd2} state_t;

    logic [TW-1:0] tail_q, tail_d;
    logic          tail_done;
`else
    typedef enum logic {IDLE = 1'b0, DATA = 1'b1} state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [K-2:0]  sr_q, sr_d;

    logic          in_tail;
    logic          accept;
    logic          step;
    logic          last_bit;
    logic          end_hit;
    logic          u;
    logic [K-1:0]  w;
    logic [1:0]    code;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            sr_q          <= '0;
`ifdef CONV_ENC_TAIL_EN
            tail_q        <= '0;
`endif
            valid_o       <= 1'b0;
            d_out         <= 2'b00;
            frame_start_o <= 1'b0;
            frame_end_o   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sr_q          <= sr_d;
`ifdef CONV_ENC_TAIL_EN
            tail_q        <= tail_d;
`endif
            valid_o       <= step;
            if (step) begin
                d_out <= code;
            end
            frame_start_o <= accept && (state_q == IDLE);
            frame_end_o   <= end_hit;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
`ifdef CONV_ENC_TAIL_EN
        tail_d  = tail_q;
`endif
        // the window's upper K-1 bits become the new history
        if (step) begin
            sr_d = w[K-1:1];
        end
        if (accept) begin
            cnt_d = last_bit ? '0 : cnt_q + 1'b1;
        end
        case (state_q)
            IDLE, DATA: begin
                if (last_bit) begin
`ifdef CONV_ENC_TAIL_EN
                    state_d = TAIL;
`else
                    state_d = IDLE;
`endif
                end else if (accept) begin
                    state_d = DATA;
                end
            end
`ifdef CONV_ENC_TAIL_EN
            TAIL: begin
                tail_d = tail_q + 1'b1;
                if (tail_done) begin
                    state_d = IDLE;
                    tail_d  = '0;
                    sr_d    = '0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
`ifdef CONV_ENC_TAIL_EN
        in_tail   = (state_q == TAIL);
        tail_done = (tail_q == TAIL_LAST);
        end_hit   = in_tail && tail_done;
`else
        in_tail   = 1'b0;
`endif
        ready_o  = !in_tail;
        accept   = enable_i && ready_o;
        step     = accept || in_tail;
        last_bit = accept && (cnt_q == CNT_LAST);
`ifndef CONV_ENC_TAIL_EN
        end_hit  = last_bit;
`endif
        u        = d_in && !in_tail;
        w        = {u, sr_q};
        code     = {^(w & G0), ^(w & G1)};
    end

endmodule

// File: tb/tb_conv_encoder_framed.sv
// Scoreboard bench for conv_encoder_framed; covers both CONV_ENC_TAIL_EN builds.
module tb_conv_encoder_framed;
`ifdef CONV_ENC_TAIL_EN
    localparam int FL = 4;
`else
    localparam int FL = 2;
`endif

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       enable_i = 1'b0;
    logic       d_in     = 1'b0;
    logic       ready_o;
    logic       valid_o;
    logic [1:0] d_out;
    logic       frame_start_o;
    logic       frame_end_o;

    logic [7:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;

    conv_encoder_framed #(
        .K(3),
        .G0(3'b111),
        .G1(3'b101),
        .FRAME_LEN(FL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable_i(enable_i),
        .d_in(d_in),
        .ready_o(ready_o),
        .valid_o(valid_o),
        .d_out(d_out),
        .frame_start_o(frame_start_o),
        .frame_end_o(frame_end_o)
    );

    always #5 clk = ~clk;

    // reference encoder for generators 7 and 5 (octal)
    function automatic logic [1:0] enc(input logic u, input logic [1:0] s);
        logic [2:0] w;
        w = {u, s};
        return {^(w & 3'b111), ^(w & 3'b101)};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] d, input logic fs, input logic fe);
        exp_q.push_back({4'b0000, d, fs, fe});
    endtask

    task automatic step(input logic en, input logic b, input logic rdy);
        chk("ready_o", {7'd0, ready_o}, {7'd0, rdy});
        enable_i = en;
        d_in     = b;
        @(posedge clk);
        #1;
        enable_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        n_vec++;
        assert (exp_q.size() == 0) else begin
            n_err++;
            $error("FAIL drain: observed %0d codewords pending expected 0", exp_q.size());
        end
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic abort();
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("async_reset {ready,valid,d_out,fs,fe}",
            {2'b00, ready_o, valid_o, d_out, frame_start_o, frame_end_o}, 8'b00100000);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst && valid_o) begin
            n_vec++;
            assert (exp_q.size() > 0) else begin
                n_err++;
                $error("FAIL extra_codeword: observed d_out=%b with nothing expected", d_out);
            end
            if (exp_q.size() > 0) begin
                chk("codeword {d_out,fs,fe}", {4'b0000, d_out, frame_start_o, frame_end_o},
                    exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] m_sr;
        logic       b;
        int         gaps;

        repeat (3) @(posedge clk);
        #1;
        chk("reset {ready,valid,d_out,fs,fe}",
            {2'b00, ready_o, valid_o, d_out, frame_start_o, frame_end_o}, 8'b00100000);
        rst = 1'b1;
        @(posedge clk);
        #1;

`ifdef CONV_ENC_TAIL_EN
        // impulse
        push(2'b11, 1, 0); push(2'b10, 0, 0); push(2'b11, 0, 0);
        push(2'b00, 0, 0); push(2'b00, 0, 0); push(2'b00, 0, 1);
        step(1, 1, 1); step(1, 0, 1); step(1, 0, 1); step(1, 0, 1);
        step(0, 0, 0); step(0, 0, 0);
        drain();

        // pattern 1,0,1,1
        push(2'b11, 1, 0); push(2'b10, 0, 0); push(2'b00, 0, 0);
        push(2'b01, 0, 0); push(2'b01, 0, 0); push(2'b11, 0, 1);
        step(1, 1, 1); step(1, 0, 1); step(1, 1, 1); step(1, 1, 1);
        step(0, 0, 0); step(0, 0, 0);
        drain();

        // same pattern with a 3-cycle gap
        push(2'b11, 1, 0); push(2'b10, 0, 0); push(2'b00, 0, 0);
        push(2'b01, 0, 0); push(2'b01, 0, 0); push(2'b11, 0, 1);
        step(1, 1, 1); step(1, 0, 1);
        step(0, 1, 1); step(0, 1, 1); step(0, 1, 1);
        step(1, 1, 1); step(1, 1, 1);
        step(0, 0, 0); step(0, 0, 0);
        drain();

        // enable held high through TAIL, next frame starts right after
        push(2'b11, 1, 0); push(2'b10, 0, 0); push(2'b11, 0, 0);
        push(2'b00, 0, 0); push(2'b00, 0, 0); push(2'b00, 0, 1);
        step(1, 1, 1); step(1, 0, 1); step(1, 0, 1); step(1, 0, 1);
        step(1, 1, 0); step(1, 1, 0);
        push(2'b11, 1, 0); step(1, 1, 1);
        push(2'b01, 0, 0); step(1, 1, 1);
        abort();

        // frame after abort must start from a cleared register
        push(2'b11, 1, 0); push(2'b01, 0, 0); push(2'b01, 0, 0);
        push(2'b11, 0, 0); push(2'b00, 0, 0); push(2'b00, 0, 1);
        step(1, 1, 1); step(1, 1, 1); step(1, 0, 1); step(1, 0, 1);
        step(0, 0, 0); step(0, 0, 0);
        drain();

        // random frames with random gaps and random enable during TAIL
        m_sr = 2'b00;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < FL; i++) begin
                gaps = $urandom_range(0, 2);
                for (int g = 0; g < gaps; g++) step(1'b0, 1'($urandom_range(0, 1)), 1'b1);
                b = 1'($urandom_range(0, 1));
                push(enc(b, m_sr), i == 0, 1'b0);
                m_sr = {b, m_sr[1]};
                step(1'b1, b, 1'b1);
            end
            for (int t = 0; t < 2; t++) begin
                push(enc(1'b0, m_sr), 1'b0, t == 1);
                m_sr = {1'b0, m_sr[1]};
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            end
        end
        drain();
`else
        // 1,1 then 0,0 with state carried across frames
        push(2'b11, 1, 0); push(2'b01, 0, 1); push(2'b01, 1, 0); push(2'b11, 0, 1);
        step(1, 1, 1); step(1, 1, 1); step(1, 0, 1); step(1, 0, 1);
        drain();

        // gapped frames: 1,0 | gap | 1,1
        push(2'b11, 1, 0); push(2'b10, 0, 1); push(2'b00, 1, 0); push(2'b01, 0, 1);
        step(1, 1, 1); step(1, 0, 1);
        step(0, 1, 1); step(0, 1, 1); step(0, 1, 1);
        step(1, 1, 1); step(1, 1, 1);
        drain();

        // register holds 11; abort mid-frame, then it must restart from 00
        push(2'b10, 1, 0); step(1, 1, 1);
        abort();
        push(2'b11, 1, 0); push(2'b01, 0, 1);
        step(1, 1, 1); step(1, 1, 1);
        drain();

        // random continuous stream with gaps
        m_sr = 2'b11;
        for (int i = 0; i < 8 * FL; i++) begin
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) step(1'b0, 1'($urandom_range(0, 1)), 1'b1);
            b = 1'($urandom_range(0, 1));
            push(enc(b, m_sr), (i % FL) == 0, (i % FL) == FL - 1);
            m_sr = {b, m_sr[1]};
            step(1'b1, b, 1'b1);
        end
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
